// File: rtl/aes_plat_pkg.sv
// aes_plat_pkg: command bytes, state encoding and frame size shared by the AES UART controller.
package aes_plat_pkg;

    localparam logic [7:0] CMD_KEY  = "K";
    localparam logic [7:0] CMD_DATA = "P";
    localparam logic [7:0] CMD_ENC  = "E";
    localparam logic [7:0] CMD_DEC  = "D";
    localparam logic [7:0] CMD_CLR  = "C";

    localparam int BLOCK_BYTES = 16;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RX_KEY  = 3'd1;
    localparam logic [2:0] S_RX_DATA = 3'd2;
    localparam logic [2:0] S_START   = 3'd3;
    localparam logic [2:0] S_WAIT    = 3'd4;
    localparam logic [2:0] S_TX      = 3'd5;

    typedef enum logic [2:0] {
        IDLE    = S_IDLE,
        RX_KEY  = S_RX_KEY,
        RX_DATA = S_RX_DATA,
        START   = S_START,
        WAIT    = S_WAIT,
        TX      = S_TX
    } state_t;

endpackage

// File: rtl/aes_ctrl_timeout.sv
// aes_ctrl_timeout: loadable saturating down-counter; expired while the count sits at zero.
module aes_ctrl_timeout #(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam int W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] INIT = W'(LIMIT);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= INIT;
        else if (clear)
            cnt <= INIT;
        else if (en && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/aes_uart_ctrl.sv
// aes_uart_ctrl: UART command sequencer that collects key/data frames, runs the AES core and streams the result back.
module aes_uart_ctrl import aes_plat_pkg::*; #(
    parameter int BYTE_TIMEOUT = 50_000_000,
    parameter int AES_TIMEOUT  = 1024
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         rx_valid,
    input  logic [7:0]   rx_data,
    output logic [7:0]   tx_data,
    output logic         tx_valid,
    input  logic         tx_ready,
    output logic [127:0] aes_key,
    output logic [127:0] aes_din,
    output logic         aes_enc,
    output logic         aes_start,
    input  logic         aes_done,
    input  logic [127:0] aes_dout,
    output logic         busy,
    output logic         err,
    output logic         drop
);

    state_t       state;
    logic [3:0]   cnt;
    logic [119:0] stage;
    logic [119:0] res;
    logic         in_rx;
    logic         byte_exp;
    logic         aes_exp;

    assign in_rx = (state == RX_KEY) || (state == RX_DATA);
    assign busy  = (state != IDLE);

    aes_ctrl_timeout #(.LIMIT(BYTE_TIMEOUT)) u_byte_to (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (rx_valid || !in_rx),
        .en      (in_rx),
        .expired (byte_exp)
    );

    aes_ctrl_timeout #(.LIMIT(AES_TIMEOUT)) u_aes_to (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state != WAIT),
        .en      (state == WAIT),
        .expired (aes_exp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            stage     <= '0;
            res       <= '0;
            tx_data   <= '0;
            tx_valid  <= 1'b0;
            aes_key   <= '0;
            aes_din   <= '0;
            aes_enc   <= 1'b1;
            aes_start <= 1'b0;
            err       <= 1'b0;
            drop      <= 1'b0;
        end else begin
            err       <= 1'b0;
            aes_start <= 1'b0;
            case (state)
                IDLE: if (rx_valid) begin
                    cnt <= '0;
                    case (rx_data)
                        CMD_KEY:  state   <= RX_KEY;
                        CMD_DATA: state   <= RX_DATA;
                        CMD_ENC:  aes_enc <= 1'b1;
                        CMD_DEC:  aes_enc <= 1'b0;
                        CMD_CLR:  drop    <= 1'b0;
                        default:  err     <= 1'b1;
                    endcase
                end
                RX_KEY, RX_DATA: begin
                    // A byte arriving on the expiry cycle takes priority over the timeout
                    if (rx_valid) begin
                        stage <= {stage[111:0], rx_data};
                        cnt   <= cnt + 4'd1;
                        if (cnt == 4'(BLOCK_BYTES - 1)) begin
                            if (state == RX_KEY) begin
                                aes_key <= {stage, rx_data};
                                state   <= IDLE;
                            end else begin
                                aes_din <= {stage, rx_data};
                                state   <= START;
                            end
                        end
                    end else if (byte_exp) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end
                end
                START: begin
                    aes_start <= 1'b1;
                    state     <= WAIT;
                end
                WAIT: if (aes_done) begin
                    res      <= aes_dout[119:0];
                    tx_data  <= aes_dout[127:120];
                    tx_valid <= 1'b1;
                    cnt      <= '0;
                    state    <= TX;
                end else if (aes_exp) begin
                    err   <= 1'b1;
                    state <= IDLE;
                end
                TX: if (tx_ready) begin
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'(BLOCK_BYTES - 1)) begin
                        tx_valid <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        tx_data <= res[119:112];
                        res     <= {res[111:0], 8'h00};
                    end
                end
                default: state <= IDLE;
            endcase
            if (rx_valid && busy && !in_rx)
                drop <= 1'b1;
        end
    end

endmodule

// File: doc/aes_uart_ctrl.md
Name: aes_uart_ctrl

Overview:
Command sequencer between the UART byte receiver/transmitter and the AES-128 core on the verify platform.
- Parses single-letter command bytes and collects 16-byte key and data frames.
- Loads the AES operand registers, issues a start pulse and waits for completion.
- Streams the 16-byte result back through the UART transmit byte handshake.

Parameters:
BYTE_TIMEOUT, 50_000_000, max clk cycles between bytes of a frame before abort (1 s at 50 MHz)
AES_TIMEOUT, 1024, max clk cycles from aes_start to aes_done before abort

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
rx_valid  input  1  one-cycle strobe, rx_data holds a received byte
rx_data  input  8  received byte
tx_data  output  8  byte to transmit
tx_valid  output  1  tx_data valid; held until tx_ready
tx_ready  input  1  transmitter accepts tx_data when tx_valid&tx_ready
aes_key  output  128  key register to AES core
aes_din  output  128  plaintext/ciphertext register to AES core
aes_enc  output  1  1=encrypt, 0=decrypt
aes_start  output  1  one-cycle start pulse
aes_done  input  1  one-cycle completion strobe, aes_dout valid that cycle
aes_dout  input  128  AES result
busy  output  1  high in every state except IDLE
err  output  1  one-cycle pulse on any protocol error
drop  output  1  sticky: a byte was received while not accepting; cleared by 'C' command or reset

Behaviour:
- Reset values: tx_data=0, tx_valid=0, aes_key=0, aes_din=0, aes_enc=1, aes_start=0, busy=0, err=0, drop=0, state=IDLE.
- States: IDLE, RX_KEY, RX_DATA, START, WAIT, TX.
- IDLE, on rx_valid:
  - 'K' -> RX_KEY, byte counter=0.
  - 'P' -> RX_DATA, counter=0.
  - 'E' -> aes_enc=1; 'D' -> aes_enc=0; 'C' -> drop=0; all three stay in IDLE.
  - Any other byte -> err pulse next cycle, stay IDLE.
- RX_KEY/RX_DATA:
  - Each rx_valid shifts the byte in MSB-first; first byte lands in [127:120], 16th in [7:0].
  - After the 16th byte: RX_KEY -> IDLE; RX_DATA -> START.
  - Shift is into a staging register. aes_key/aes_din update only on the 16th byte, so an aborted frame leaves the previous value intact.
- Byte timeout:
  - Idle counter resets on each rx_valid.
  - If it reaches BYTE_TIMEOUT with no byte in RX_KEY/RX_DATA -> err pulse, state=IDLE, partial frame discarded.
- START: aes_start=1 for exactly one cycle -> WAIT. aes_din is stable from START until exit from WAIT.
- WAIT:
  - On aes_done, capture aes_dout into the result register -> TX, tx counter=0.
  - If AES_TIMEOUT cycles elapse after aes_start without aes_done -> err pulse, IDLE.
  - aes_done in any other state is ignored.
- TX:
  - tx_data = result byte [127-8n -: 8], n=0..15; tx_valid=1.
  - On tx_valid&tx_ready, n increments and the next byte is presented the following cycle; tx_valid may stay high back-to-back.
  - After byte 15 accepted -> IDLE, tx_valid=0.
  - tx_data/tx_valid must not change while tx_valid=1 and tx_ready=0.
- Dropped bytes: rx_valid in START/WAIT/TX sets drop=1; the byte is discarded with no err pulse.
- Simultaneous events: rx_valid coinciding with byte timeout expiry -> the byte wins, timeout does not fire.
- Reset mid-operation: asynchronous return to IDLE; all outputs to reset values; partial frames and results lost.
- Counters:
  - Byte and tx counters: 4 bits, wrap only at frame end.
  - Timeout counters: width = $clog2(param+1), saturating, never wrap.

Decomposition:
- Shared package aes_plat_pkg:
  - Command byte constants CMD_KEY='K', CMD_DATA='P', CMD_ENC='E', CMD_DEC='D', CMD_CLR='C'.
  - State encoding localparams.
  - BLOCK_BYTES=16.
- One natural sub-module: aes_ctrl_timeout. A loadable saturating down-counter (clear, enable, expired), instantiated twice (byte and AES timeouts).

Test Plan:
- Encrypt vector: send 'K',000102030405060708090a0b0c0d0e0f, 'E', 'P',00112233445566778899aabbccddeeff, bench AES model -> aes_start single pulse with aes_din/aes_key as sent, aes_enc=1, tx bytes 69 c4 e0 d8 6a 7b 04 30 d8 cd b7 80 70 b4 c5 5a in order, then busy=0.
- Decrypt vector: 'D', 'P',69c4e0d86a7b0430d8cdb78070b4c55a -> aes_enc=0 at start, tx bytes 00 11 22 … ff; key retained from previous test.
- Backpressure: hold tx_ready low 20 cycles on byte 3, then toggle randomly -> tx_data stable while stalled, exactly 16 bytes, no duplicates or skips.
- Byte timeout: 'K' plus 5 bytes, then silence BYTE_TIMEOUT (reduced to 100 in bench) cycles -> single err pulse, state IDLE, aes_key unchanged.
- Errors and drops: send 'X' in IDLE -> err pulse, no state change. Send a byte during WAIT -> drop=1, result still transmitted. Then 'C' -> drop=0. Withhold aes_done -> err after AES_TIMEOUT, no tx.
- Reset mid-TX: assert rst_n low after byte 7 accepted -> tx_valid=0, busy=0 immediately. A fresh 'P' frame afterwards completes normally.
